// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state enum, operand magnitude/sign helper and parameter check.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the helper function can handle.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic             neg;
        logic [MAX_W-1:0] mag;
    } mag_sign_t;

    // Magnitude and sign of a w-bit operand held zero-extended in v.
    // Only the low w bits of mag are meaningful.
    function automatic mag_sign_t mag_sign(
        input logic [MAX_W-1:0] v,
        input int               w,
        input logic             sgn
    );
        mag_sign_t        r;
        logic [MAX_W-1:0] msb;
        msb   = v >> (w - 1);
        r.neg = sgn & msb[0];
        r.mag = r.neg ? (~v + 1'b1) : v;
        return r;
    endfunction

    function automatic bit params_legal(
        input int iw,
        input int ow,
        input int bpc
    );
        return (iw >= 2) && (iw <= MAX_W) && (ow == 2 * iw) &&
               (bpc >= 1) && (bpc <= iw) && (iw % bpc == 0) &&
               ((bpc & (bpc - 1)) == 0);
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One partial-product step: acc + (mcand * bits) << offset, combinational.
// Ports: acc/mcand/bits/offset in, sum out (out_width bits).
module mult_pp_step
    import mult_pkg::*;
#(
    parameter int in_width       = 8,
    parameter int out_width      = 16,
    parameter int bits_per_cycle = 1,
    parameter int off_width      = 4
) (
    input  logic [out_width-1:0]      acc,
    input  logic [in_width-1:0]       mcand,
    input  logic [bits_per_cycle-1:0] bits,
    input  logic [off_width-1:0]      offset,
    output logic [out_width-1:0]      sum
);

    logic [out_width-1:0] pp;

    always_comb begin
        pp  = out_width'(mcand) * out_width'(bits);
        sum = acc + (pp << offset);
    end

endmodule

// File: rtl/mult_seq.sv
// Handshaked iterative shift-add multiplier, signed or unsigned per operation.
// Ports: clk, rst, operands + ctrl_signed with in_valid/in_ready,
//        data_result with out_valid/out_ready, ctrl_busy status.
module mult_seq
    import mult_pkg::*;
#(
    parameter int in_width       = 8,
    parameter int out_width      = 2 * in_width,
    parameter int bits_per_cycle = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [in_width-1:0]  data_multiplicand,
    input  logic [in_width-1:0]  data_multiplier,
    input  logic                 ctrl_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [out_width-1:0] data_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ctrl_busy
);

    localparam int N   = in_width / bits_per_cycle;
    localparam int CW  = $clog2(N + 1);
    localparam int OFW = $clog2(out_width);

    if (!params_legal(in_width, out_width, bits_per_cycle)) begin : g_bad
        $error("mult_seq: illegal in_width/out_width/bits_per_cycle");
    end

    state_t               state;
    logic [in_width-1:0]  a_mag;
    logic [in_width-1:0]  b_sh;
    logic                 neg;
    logic [out_width-1:0] acc;
    logic [CW-1:0]        cnt;

    mag_sign_t            a_ms;
    mag_sign_t            b_ms;
    logic [OFW-1:0]       offset;
    logic [out_width-1:0] sum;
    logic                 last;

    always_comb begin
        a_ms   = mag_sign(MAX_W'(data_multiplicand), in_width, ctrl_signed);
        b_ms   = mag_sign(MAX_W'(data_multiplier), in_width, ctrl_signed);
        offset = OFW'(cnt) * OFW'(bits_per_cycle);
        last   = (cnt == CW'(N - 1));
    end

    // Only the low in_width bits of the helper's magnitude are used.
    if (in_width < MAX_W) begin : g_sink
        logic unused_hi;
        assign unused_hi = ^{a_ms.mag[MAX_W-1:in_width],
                             b_ms.mag[MAX_W-1:in_width]};
    end

    mult_pp_step #(
        .in_width      (in_width),
        .out_width     (out_width),
        .bits_per_cycle(bits_per_cycle),
        .off_width     (OFW)
    ) u_step (
        .acc   (acc),
        .mcand (a_mag),
        .bits  (b_sh[bits_per_cycle-1:0]),
        .offset(offset),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            ctrl_busy   <= 1'b0;
            data_result <= '0;
            a_mag       <= '0;
            b_sh        <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_mag     <= a_ms.mag[in_width-1:0];
                        b_sh      <= b_ms.mag[in_width-1:0];
                        // Both flags are zero for unsigned operations.
                        neg       <= a_ms.neg ^ b_ms.neg;
                        acc       <= '0;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        ctrl_busy <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    acc  <= sum;
                    b_sh <= b_sh >> bits_per_cycle;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        data_result <= neg ? -sum : sum;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Input stays blocked until the cycle after the handoff.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        ctrl_busy <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: 8-bit/bpc=1 and 16-bit/bpc=4 instances.
// Latency is counted in edges, the accepting edge being edge 1.
module tb_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [7:0]  a8, b8;
    logic        s8, v8, ir8, ov8, or8, bz8;
    logic [15:0] r8;

    logic [15:0] a16, b16;
    logic        s16, v16, ir16, ov16, or16, bz16;
    logic [31:0] r16;

    int checks = 0;
    int errors = 0;

    mult_seq #(.in_width(8), .out_width(16), .bits_per_cycle(1)) u8 (
        .clk(clk), .rst(rst),
        .data_multiplicand(a8), .data_multiplier(b8),
        .ctrl_signed(s8), .in_valid(v8), .in_ready(ir8),
        .data_result(r8), .out_valid(ov8), .out_ready(or8),
        .ctrl_busy(bz8)
    );

    mult_seq #(.in_width(16), .out_width(32), .bits_per_cycle(4)) u16 (
        .clk(clk), .rst(rst),
        .data_multiplicand(a16), .data_multiplier(b16),
        .ctrl_signed(s16), .in_valid(v16), .in_ready(ir16),
        .data_result(r16), .out_valid(ov16), .out_ready(or16),
        .ctrl_busy(bz16)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model16(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic s);
        logic signed [31:0] ps;
        logic [31:0]        pu;
        ps = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        pu = {16'd0, a} * {16'd0, b};
        return s ? ps : pu;
    endfunction

    // Present operands and return just after the accepting edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b,
                          input logic s);
        int n = 0;
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        while (!ir8 && n < 40) begin tick(); n++; end
        check("ready8", 64'(ir8), 64'd1);
        tick();
        v8 = 1'b0;
        a8 = ~a; b8 = ~b; s8 = ~s;
        check("busy8", 64'(bz8), 64'd1);
    endtask

    task automatic finish8(input string tag, input logic [15:0] exp);
        int n = 1;
        while (!ov8 && n < 40) begin tick(); n++; end
        check({tag, "_lat"}, 64'(n), 64'd9);
        check({tag, "_res"}, 64'(r8), 64'(exp));
    endtask

    task automatic ack8();
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("ack8_ov", 64'(ov8), 64'd0);
        check("ack8_ir", 64'(ir8), 64'd1);
    endtask

    task automatic run16(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic s);
        int n = 0;
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        while (!ir16 && n < 40) begin tick(); n++; end
        tick();
        v16 = 1'b0;
        n = 1;
        while (!ov16 && n < 40) begin tick(); n++; end
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_res"}, 64'(r16), 64'(model16(a, b, s)));
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
    endtask

    logic [15:0] sa [20];
    logic [15:0] sb [20];
    logic        ss [20];

    initial begin
        logic [15:0] held;
        int idx, got, last_cyc;
        bit acc_now;

        rst = 1'b1;
        a8 = '0; b8 = '0; s8 = 1'b0; v8 = 1'b0; or8 = 1'b0;
        a16 = '0; b16 = '0; s16 = 1'b0; v16 = 1'b0; or16 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ir", 64'(ir8), 64'd1);
        check("rst_ov", 64'(ov8), 64'd0);
        check("rst_busy", 64'(bz8), 64'd0);
        check("rst_res", 64'(r8), 64'd0);
        check("rst_ir16", 64'(ir16), 64'd1);

        start8(8'd13, 8'd11, 1'b0); finish8("u13x11", 16'h008F); ack8();
        start8(8'hFD, 8'h05, 1'b1); finish8("sm3x5", 16'hFFF1); ack8();
        start8(8'h80, 8'h80, 1'b1); finish8("smin2", 16'h4000); ack8();
        start8(8'hFF, 8'hFF, 1'b0); finish8("uff", 16'hFE01); ack8();
        start8(8'hFF, 8'h01, 1'b1); finish8("sm1x1", 16'hFFFF); ack8();
        start8(8'h00, 8'h5A, 1'b0); finish8("zero", 16'h0000); ack8();

        // out_ready raised early changes nothing.
        or8 = 1'b1;
        start8(8'd9, 8'd7, 1'b0);
        or8 = 1'b1;
        finish8("early_rdy", 16'h003F);
        tick();
        or8 = 1'b0;
        check("early_drop", 64'(ov8), 64'd0);

        // Back-pressure with a pending input during DONE.
        start8(8'h12, 8'h10, 1'b0);
        finish8("bp", 16'h0120);
        held = r8;
        a8 = 8'd3; b8 = 8'd4; s8 = 1'b0; v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 64'(r8), 64'(held));
            check("bp_ov", 64'(ov8), 64'd1);
            check("bp_ir", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("bp_drop", 64'(ov8), 64'd0);
        check("bp_noacc", 64'(ir8), 64'd1);
        tick();
        v8 = 1'b0;
        check("bp_acc", 64'(ir8), 64'd0);
        finish8("after_bp", 16'h000C);
        ack8();

        // Reset during the third iteration aborts the operation.
        start8(8'd100, 8'd100, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ir", 64'(ir8), 64'd1);
        check("abort_ov", 64'(ov8), 64'd0);
        check("abort_busy", 64'(bz8), 64'd0);
        check("abort_res", 64'(r8), 64'd0);
        start8(8'd7, 8'd6, 1'b0); finish8("fresh", 16'h002A); ack8();

        // 16-bit, four bits per cycle.
        run16("w_smin", 16'h8000, 16'h8000, 1'b1);
        run16("w_uff", 16'hFFFF, 16'hFFFF, 1'b0);
        run16("w_mix", 16'h7FFF, 16'h8000, 1'b1);
        run16("w_rnd", 16'h1234, 16'hABCD, 1'b1);

        sa[0] = 16'h8000; sb[0] = 16'h8000; ss[0] = 1'b1;
        sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; ss[1] = 1'b0;
        sa[2] = 16'h0000; sb[2] = 16'h1234; ss[2] = 1'b1;
        sa[3] = 16'hFFFF; sb[3] = 16'h0002; ss[3] = 1'b1;
        for (int i = 4; i < 20; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            ss[i] = 1'($urandom);
        end

        // Streaming: valid and ready held high.
        idx = 0; got = 0; last_cyc = 0;
        a16 = sa[0]; b16 = sb[0]; s16 = ss[0];
        v16 = 1'b1; or16 = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            acc_now = ir16 && v16;
            if (ov16) begin
                check("stream_res", 64'(r16),
                      64'(model16(sa[got], sb[got], ss[got])));
                if (got > 0)
                    check("stream_gap", 64'(cyc - last_cyc), 64'd6);
                last_cyc = cyc;
                got++;
            end
            tick();
            if (acc_now) begin
                idx++;
                if (idx < 20) begin
                    a16 = sa[idx]; b16 = sb[idx]; s16 = ss[idx];
                end else begin
                    v16 = 1'b0;
                end
            end
        end
        check("stream_cnt", 64'(got), 64'd20);
        for (int i = 0; i < 8; i++) tick();
        check("stream_nodup", 64'(ov16), 64'd0);
        or16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
